// File: rtl/sm_conv_arbiter.sv
// sm_conv_arbiter: round-robin arbiter sharing one sign-magnitude to two's-complement converter.
// Define SM_OVF_FLAG_EN to add the registered out_ovf range flag.
module sm_conv_arbiter #(
    parameter int N = 5,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_mag,
    input  logic [NREQ-1:0]   req_sign,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
`ifdef SM_OVF_FLAG_EN
    output logic              out_ovf,
`endif
    input  logic              out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [IDW-1:0] ptr, g, idx;
    logic found, can_load, accept;
    logic [N-1:0] mag, conv;

    // NREQ is a power of two, so the IDW-bit add wraps the search modulo NREQ
    always_comb begin
        found = 1'b0;
        g = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
    end

    assign mag  = req_mag[g*N +: N];
    assign conv = req_sign[g] ? ~mag + N'(1) : mag;

    always_comb begin
        can_load  = (state == EMPTY) || out_ready;
        req_ready = (rst_n && found && can_load) ? NREQ'(1) << g : '0;
        accept    = |(req_valid & req_ready);
        out_valid = (state == FULL);
        state_nx  = accept ? FULL : (out_ready ? EMPTY : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_data <= conv;
                out_id   <= g;
                ptr      <= g + IDW'(1);
            end
        end
    end

`ifdef SM_OVF_FLAG_EN
    localparam logic [N-1:0] HALF = N'(1) << (N - 1);
    logic ovf;
    assign ovf = req_sign[g] ? (mag > HALF) : mag[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_ovf <= 1'b0;
        else if (accept) out_ovf <= ovf;
    end
`endif
endmodule

// File: tb/tb_sm_conv_arbiter.sv
// tb_sm_conv_arbiter: scenario tasks plus a negedge reference model / result scoreboard.
module tb_sm_conv_arbiter;
    localparam int N = 5;
    localparam int NREQ = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*N-1:0] req_mag = '0;
    logic [NREQ-1:0] req_sign = '0;
    logic [NREQ-1:0] req_ready;
    logic out_valid;
    logic [N-1:0] out_data;
    logic [IDW-1:0] out_id;
    logic out_ready = 1'b0;
`ifdef SM_OVF_FLAG_EN
    logic out_ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [N-1:0]   data;
        logic           ovf;
    } exp_t;
    exp_t q[$];
    logic m_full = 1'b0;
    int m_ptr = 0;

    sm_conv_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_mag(req_mag),
        .req_sign(req_sign),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_id(out_id),
`ifdef SM_OVF_FLAG_EN
        .out_ovf(out_ovf),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_conv(input int mag, input bit s);
        int v;
        v = s ? ((1 << N) - mag) % (1 << N) : mag;
        return N'(v);
    endfunction

    function automatic logic m_ovf(input int mag, input bit s);
        return s ? (mag > (1 << (N - 1))) : (mag >= (1 << (N - 1)));
    endfunction

    // Reference model: predicts req_ready, queues results on accept, compares on output.
    always @(negedge clk) begin : mon
        int g;
        bit found;
        logic [NREQ-1:0] er;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_full = 1'b0;
            m_ptr = 0;
        end else begin
            found = 0;
            g = 0;
            for (int k = 0; k < NREQ; k++)
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    g = (m_ptr + k) % NREQ;
                end
            er = (found && (!m_full || out_ready)) ? NREQ'(1) << g : '0;
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL sb_ready: got %b want %b", req_ready, er);
            end
            checks++;
            if (out_valid !== m_full) begin
                errors++;
                $display("FAIL sb_valid: got %b want %b", out_valid, m_full);
            end
            if (m_full && q.size() > 0) begin
                checks++;
                if (out_id !== q[0].id || out_data !== q[0].data) begin
                    errors++;
                    $display("FAIL sb_result: got id=%0d data=%b want id=%0d data=%b",
                             out_id, out_data, q[0].id, q[0].data);
                end
`ifdef SM_OVF_FLAG_EN
                checks++;
                if (out_ovf !== q[0].ovf) begin
                    errors++;
                    $display("FAIL sb_ovf: got %b want %b", out_ovf, q[0].ovf);
                end
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (er != 0) begin
                e.id = IDW'(g);
                e.data = m_conv(int'(req_mag[g*N +: N]), req_sign[g]);
                e.ovf = m_ovf(int'(req_mag[g*N +: N]), req_sign[g]);
                q.push_back(e);
                m_ptr = (g + 1) % NREQ;
            end
            m_full = (er != 0) || (m_full && !out_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_hs: got valid=%b ready=%b want 0/0000", out_valid, req_ready);
        end
        checks++;
        if (out_data !== '0 || out_id !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%b id=%0d want 0/0", out_data, out_id);
        end
`ifdef SM_OVF_FLAG_EN
        checks++;
        if (out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", out_ovf);
        end
`endif
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_mag[2*N +: N] = 5'd5;
        req_sign[2] = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 5'b11011 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b data=%b id=%0d want 1/11011/2",
                     out_valid, out_data, out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) req_mag[i*N +: N] = N'(i + 3);
        req_sign = 4'b1010;
        req_valid = '1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_id !== IDW'(i % NREQ)) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d want 1/%0d", i, out_valid, out_id, i % NREQ);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_ovf_ops();
        int mags[4] = '{0, 16, 16, 17};
        bit sgns[4] = '{1, 1, 0, 1};
        logic [N-1:0] ed[4] = '{5'b00000, 5'b10000, 5'b10000, 5'b01111};
        logic eo[4] = '{0, 0, 1, 1};
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            req_mag[0 +: N] = N'(mags[i]);
            req_sign[0] = sgns[i];
            tick();
            checks++;
            if (out_data !== ed[i] || out_id !== 2'd0) begin
                errors++;
                $display("FAIL op[%0d]: got data=%b id=%0d want %b/0", i, out_data, out_id, ed[i]);
            end
`ifdef SM_OVF_FLAG_EN
            checks++;
            if (out_ovf !== eo[i]) begin
                errors++;
                $display("FAIL op_ovf[%0d]: got %b want %b", i, out_ovf, eo[i]);
            end
`else
            if (eo[i] !== 1'b0 && eo[i] !== 1'b1) $display("bad table entry %0d", i);
`endif
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        req_mag[1*N +: N] = 5'd9;
        req_sign[1] = 1'b0;
        tick();
        out_ready = 1'b0;
        req_valid = '1;
        req_mag[2*N +: N] = 5'd3;
        req_sign[2] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== '0 || out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 5'd9) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d data=%b want 0000/1/1/01001",
                         i, req_ready, out_valid, out_id, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_id !== 2'd2 || out_data !== 5'b11101) begin
            errors++;
            $display("FAIL bp_next: got id=%0d data=%b want 2/11101", out_id, out_data);
        end
        tick();
    endtask

    task automatic test_fairness();
        bit got = 0;
        int cnt = 0;
        do_reset();
        req_mag[0 +: N] = 5'd1;
        req_mag[3*N +: N] = 5'd7;
        req_sign = '0;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            if (c == 2) req_valid[3] = 1'b1;
            tick();
            if (c >= 2 && out_valid) begin
                cnt++;
                if (out_id == 2'd3) got = 1;
            end
        end
        checks++;
        if (!got || cnt > NREQ || cnt < 1) begin
            errors++;
            $display("FAIL fairness: got granted=%0d after %0d accepts want 1 within %0d", got, cnt, NREQ);
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL fair_skip: got %0d accepts want 1 (idle 1,2 skipped)", cnt);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b want 0", out_valid);
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0000", req_ready);
        end
        tick();
        req_valid = 4'b1010;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rst_release: got v=%b rdy=%b want 0/0010", out_valid, req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_first: got v=%b id=%0d want 1/1", out_valid, out_id);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ovf_ops();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
